// File: rtl/soc_system_pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: FSM states, CSR word
// addresses and CTRL/STATUS bit positions.
package soc_system_pio_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_WAIT  = 2'd3
    } seqState_t;

    // Addresses 4..7 (address[2] set) select the PATTERN entries.
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_INTERVAL = 3'd2;
    localparam logic [2:0] ADDR_RESERVED = 3'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_STOP  = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_MISMATCH = 2;
    localparam int STAT_INDEX_LO = 4;

endpackage

// File: rtl/soc_system_pio_sequencer_if.sv
// Simple memory-mapped bus (address/chipselect/write_n/data) used both for the
// CSR slave port and for the master port towards the PIO.
interface soc_system_pio_sequencer_if #(
    parameter int ADDR_W = 3
) ();
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_seq_timer.sv
// Interval down-counter: loads a start value, counts down while enabled and
// stops at zero.
module soc_system_pio_seq_timer
    import soc_system_pio_seq_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadValue,
    input  logic             i_enable,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/soc_system_pio_sequencer.sv
// Steps a table of patterns out to a PIO slave: write each entry, read it back,
// flag any difference, then wait INTERVAL cycles before the next entry.
module soc_system_pio_sequencer
    import soc_system_pio_seq_pkg::*;
#(
    parameter int PATTERN_DEPTH = 4,
    parameter int DATA_W        = 3,
    parameter int CNT_W         = 24
) (
    input  logic                        clk,
    input  logic                        reset_n,
    soc_system_pio_sequencer_if.slave   csr,
    soc_system_pio_sequencer_if.master  pio,
    output logic                        irq
);

    localparam int IDX_W = (PATTERN_DEPTH > 1) ? $clog2(PATTERN_DEPTH) : 1;

    seqState_t        r_state;
    logic [IDX_W-1:0] r_index;
    logic             r_loop;
    logic             r_done;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_interval;
    logic [DATA_W-1:0] r_pattern [PATTERN_DEPTH];
    logic             r_pioCs;
    logic             r_pioWriteN;
    logic [DATA_W-1:0] r_pioWriteData;

    logic             w_csrWrite, w_ctrlWrite, w_statusWrite;
    logic             w_start, w_stop, w_busy;
    logic             w_stepAdvance, w_finish, w_setDone, w_setMismatch;
    logic             w_timerLoad, w_timerZero;
    logic [1:0]       w_patSel;
    logic             w_patHit;
    logic [IDX_W-1:0] w_nextIndex;
    logic [31:0]      w_csrReadData;
    logic             w_unused;

    assign w_csrWrite    = csr.chipselect && !csr.write_n;
    assign w_ctrlWrite   = w_csrWrite && (csr.address == ADDR_CTRL);
    assign w_statusWrite = w_csrWrite && (csr.address == ADDR_STATUS);
    assign w_start       = w_ctrlWrite && csr.writedata[CTRL_START];
    assign w_stop        = w_ctrlWrite && csr.writedata[CTRL_STOP];
    assign w_busy        = (r_state != ST_IDLE);
    assign w_patSel      = csr.address[1:0];
    assign w_patHit      = csr.address[2] && (int'(w_patSel) < PATTERN_DEPTH);

    // A step ends after READ when no wait is programmed, otherwise when WAIT drains.
    assign w_stepAdvance = ((r_state == ST_READ) && (r_interval == '0)) ||
                           ((r_state == ST_WAIT) && w_timerZero);
    assign w_finish      = (r_index == IDX_W'(PATTERN_DEPTH - 1)) && !r_loop;
    assign w_nextIndex   = (r_index == IDX_W'(PATTERN_DEPTH - 1)) ? '0 : r_index + 1'b1;
    assign w_setDone     = w_stepAdvance && w_finish && !w_stop;
    assign w_setMismatch = (r_state == ST_READ) &&
                           (pio.readdata[DATA_W-1:0] != r_pattern[r_index]);

    // Loading INTERVAL-1 and leaving on zero gives exactly INTERVAL WAIT cycles.
    assign w_timerLoad   = (r_state == ST_READ) && (r_interval != '0);

    soc_system_pio_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_timerLoad),
        .i_loadValue (r_interval - 1'b1),
        .i_enable    (r_state == ST_WAIT),
        .o_zero      (w_timerZero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_interval <= '0;
            for (int i = 0; i < PATTERN_DEPTH; i++) r_pattern[i] <= '0;
        end else if (w_csrWrite) begin
            if (csr.address == ADDR_INTERVAL) r_interval <= csr.writedata[CNT_W-1:0];
            if (w_patHit) r_pattern[w_patSel] <= csr.writedata[DATA_W-1:0];
        end
    end

    // Hardware set takes priority over a coincident write-one-to-clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_done     <= (r_done && !(w_statusWrite && csr.writedata[STAT_DONE])) || w_setDone;
            r_mismatch <= (r_mismatch && !(w_statusWrite && csr.writedata[STAT_MISMATCH])) ||
                          w_setMismatch;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_index        <= '0;
            r_loop         <= 1'b0;
            r_pioCs        <= 1'b0;
            r_pioWriteN    <= 1'b1;
            r_pioWriteData <= '0;
        end else begin
            r_pioCs     <= 1'b0;
            r_pioWriteN <= 1'b1;
            if (w_stop) begin
                r_state <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_index        <= '0;
                            r_loop         <= csr.writedata[CTRL_LOOP];
                            r_state        <= ST_WRITE;
                            r_pioCs        <= 1'b1;
                            r_pioWriteN    <= 1'b0;
                            r_pioWriteData <= r_pattern[0];
                        end
                    end
                    ST_WRITE: begin
                        r_state <= ST_READ;
                        r_pioCs <= 1'b1;
                    end
                    ST_READ: begin
                        if (r_interval != '0) r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                    end
                    default: r_state <= ST_IDLE;
                endcase
                if (w_stepAdvance) begin
                    if (w_finish) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_index        <= w_nextIndex;
                        r_state        <= ST_WRITE;
                        r_pioCs        <= 1'b1;
                        r_pioWriteN    <= 1'b0;
                        r_pioWriteData <= r_pattern[w_nextIndex];
                    end
                end
            end
        end
    end

    always_comb begin
        w_csrReadData = '0;
        case (csr.address)
            ADDR_CTRL, ADDR_RESERVED: w_csrReadData = '0;
            ADDR_STATUS: begin
                w_csrReadData[STAT_BUSY]            = w_busy;
                w_csrReadData[STAT_DONE]            = r_done;
                w_csrReadData[STAT_MISMATCH]        = r_mismatch;
                w_csrReadData[STAT_INDEX_LO +: 2]   = 2'(r_index);
            end
            ADDR_INTERVAL: w_csrReadData[CNT_W-1:0] = r_interval;
            default: begin
                if (w_patHit) w_csrReadData[DATA_W-1:0] = r_pattern[w_patSel];
            end
        endcase
    end

    assign csr.readdata  = w_csrReadData;
    assign pio.address   = '0;
    assign pio.chipselect = r_pioCs;
    assign pio.write_n   = r_pioWriteN;
    assign pio.writedata = {{(32 - DATA_W){1'b0}}, r_pioWriteData};
    assign irq           = r_done || r_mismatch;

    assign w_unused = &{1'b0, pio.readdata[31:DATA_W], csr.writedata[31:CNT_W]};

endmodule

// File: tb/tb_soc_system_pio_sequencer.sv
// Directed bench for the PIO sequencer: a small PIO slave model records writes
// and echoes them back on reads; expected values are worked out by hand.
module tb_soc_system_pio_sequencer;
    import soc_system_pio_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic irq;

    always #5 clk = ~clk;

    soc_system_pio_sequencer_if #(.ADDR_W(3)) csrBus ();
    soc_system_pio_sequencer_if #(.ADDR_W(2)) pioBus ();

    soc_system_pio_sequencer #(
        .PATTERN_DEPTH (4),
        .DATA_W        (3),
        .CNT_W         (24)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .csr     (csrBus),
        .pio     (pioBus),
        .irq     (irq)
    );

    int assertCount = 0;
    int failCount   = 0;
    int cycleCount  = 0;
    int readCount   = 0;
    int readBase    = 0;
    logic corruptThirdRead = 1'b0;
    logic [31:0] slaveReg  = 32'd0;
    logic [31:0] wrData[$];
    int          wrCycle[$];

    // PIO slave: stores the last write, returns it on reads (optionally zero on read #3).
    always @(posedge clk) begin
        if (pioBus.chipselect) begin
            if (!pioBus.write_n) slaveReg <= pioBus.writedata;
            else                 readCount <= readCount + 1;
        end
    end

    always_comb begin
        pioBus.readdata = (corruptThirdRead && ((readCount - readBase) == 2)) ? 32'd0 : slaveReg;
    end

    always @(negedge clk) begin
        cycleCount++;
        if (pioBus.chipselect && !pioBus.write_n) begin
            wrData.push_back(pioBus.writedata);
            wrCycle.push_back(cycleCount);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        csrBus.address    = addr;
        csrBus.writedata  = data;
        csrBus.chipselect = 1'b1;
        csrBus.write_n    = 1'b0;
        @(negedge clk);
        csrBus.chipselect = 1'b0;
        csrBus.write_n    = 1'b1;
    endtask

    task automatic checkCsr(input string tag, input logic [2:0] addr, input logic [31:0] expected);
        csrBus.address = addr;
        #1;
        checkOutput(tag, csrBus.readdata, expected);
    endtask

    task automatic waitIrq(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (irq !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, {31'd0, irq}, 32'd1);
    endtask

    task automatic checkWrites(input string tag, input int base, input int count,
                               input logic [31:0] vals[6], input int spacing);
        checkOutput({tag, "_count"}, 32'(wrData.size() - base), 32'(count));
        if (wrData.size() >= base + count) begin
            for (int i = 0; i < count; i++) begin
                checkOutput($sformatf("%s_data%0d", tag, i), wrData[base + i], vals[i]);
                if (i > 0)
                    checkOutput($sformatf("%s_gap%0d", tag, i),
                                32'(wrCycle[base + i] - wrCycle[base + i - 1]), 32'(spacing));
            end
        end
    endtask

    logic [31:0] seqOnce[6] = '{32'd1, 32'd2, 32'd4, 32'd7, 32'd0, 32'd0};
    logic [31:0] seqLoop[6] = '{32'd1, 32'd2, 32'd4, 32'd7, 32'd1, 32'd2};

    initial begin
        int base;
        int cycles;

        csrBus.address    = '0;
        csrBus.chipselect = 1'b0;
        csrBus.write_n    = 1'b1;
        csrBus.writedata  = '0;
        reset_n           = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        checkOutput("rst_pio_cs", {31'd0, pioBus.chipselect}, 32'd0);
        checkOutput("rst_pio_wn", {31'd0, pioBus.write_n}, 32'd1);
        checkOutput("rst_pio_addr", {30'd0, pioBus.address}, 32'd0);
        checkOutput("rst_pio_wdata", pioBus.writedata, 32'd0);
        checkCsr("rst_status", ADDR_STATUS, 32'd0);
        checkCsr("rst_interval", ADDR_INTERVAL, 32'd0);
        reset_n = 1'b1;

        // Register programming, truncation and reserved/CTRL readback
        applyStimulus(3'd4, 32'd1);
        applyStimulus(3'd5, 32'd2);
        applyStimulus(3'd6, 32'hFFFF_FFFC);
        applyStimulus(3'd7, 32'd7);
        applyStimulus(ADDR_INTERVAL, 32'hFF00_0003);
        applyStimulus(ADDR_RESERVED, 32'hFFFF_FFFF);
        checkCsr("pat1_rd", 3'd5, 32'd2);
        checkCsr("pat2_trunc", 3'd6, 32'd4);
        checkCsr("interval_rd", ADDR_INTERVAL, 32'd3);
        checkCsr("reserved_rd", ADDR_RESERVED, 32'd0);
        checkCsr("ctrl_rd", ADDR_CTRL, 32'd0);

        // One-shot run, INTERVAL=3: writes every 5 cycles, done 20 cycles after first write
        base = wrData.size();
        applyStimulus(ADDR_CTRL, 32'h1);
        checkOutput("a_first_cs", {31'd0, pioBus.chipselect}, 32'd1);
        checkOutput("a_first_wn", {31'd0, pioBus.write_n}, 32'd0);
        checkOutput("a_first_addr", {30'd0, pioBus.address}, 32'd0);
        checkOutput("a_first_data", pioBus.writedata, 32'd1);
        checkCsr("a_busy", ADDR_STATUS, 32'h01);
        waitIrq("a_done_irq", 40, cycles);
        checkOutput("a_done_latency", 32'(cycles), 32'd20);
        checkWrites("a_wr", base, 4, seqOnce, 5);
        checkCsr("a_status_done", ADDR_STATUS, 32'h32);
        checkOutput("a_idle_cs", {31'd0, pioBus.chipselect}, 32'd0);
        checkOutput("a_hold_data", pioBus.writedata, 32'd7);
        applyStimulus(ADDR_STATUS, 32'h2);
        checkCsr("a_done_clr", ADDR_STATUS, 32'h30);
        checkOutput("a_irq_clr", {31'd0, irq}, 32'd0);

        // Looping run, INTERVAL=0, stopped during the READ of the sixth step
        applyStimulus(ADDR_INTERVAL, 32'd0);
        base = wrData.size();
        applyStimulus(ADDR_CTRL, 32'h3);
        repeat (10) @(negedge clk);
        applyStimulus(ADDR_CTRL, 32'h4);
        checkOutput("b_stop_cs", {31'd0, pioBus.chipselect}, 32'd0);
        checkCsr("b_stop_status", ADDR_STATUS, 32'h10);
        checkOutput("b_stop_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(negedge clk);
        checkWrites("b_wr", base, 6, seqLoop, 2);

        // Third read returns 0: mismatch raised, cleared by W1C; then a done set
        // coinciding with a done W1C must survive
        applyStimulus(ADDR_INTERVAL, 32'd1);
        readBase = readCount;
        corruptThirdRead = 1'b1;
        applyStimulus(ADDR_CTRL, 32'h1);
        waitIrq("c_mis_irq", 30, cycles);
        checkOutput("c_mis_latency", 32'(cycles), 32'd8);
        checkCsr("c_mis_status", ADDR_STATUS, 32'h25);
        applyStimulus(ADDR_STATUS, 32'h4);
        checkOutput("c_mis_irq_clr", {31'd0, irq}, 32'd0);
        checkCsr("c_mis_clr_status", ADDR_STATUS, 32'h31);
        applyStimulus(ADDR_STATUS, 32'h2);
        checkCsr("c_set_wins", ADDR_STATUS, 32'h32);
        checkOutput("c_set_wins_irq", {31'd0, irq}, 32'd1);
        corruptThirdRead = 1'b0;
        applyStimulus(ADDR_STATUS, 32'h2);
        checkCsr("c_final_clr", ADDR_STATUS, 32'h30);

        // Start while busy is ignored (its loop bit must not take effect)
        applyStimulus(ADDR_INTERVAL, 32'd3);
        base = wrData.size();
        applyStimulus(ADDR_CTRL, 32'h1);
        applyStimulus(ADDR_CTRL, 32'h3);
        checkCsr("d_busy_restart", ADDR_STATUS, 32'h01);
        waitIrq("d_done_irq", 40, cycles);
        checkOutput("d_done_latency", 32'(cycles), 32'd18);
        checkWrites("d_wr", base, 4, seqOnce, 5);
        applyStimulus(ADDR_STATUS, 32'h2);

        // Start+stop together: from IDLE nothing starts; while busy it stops
        base = wrData.size();
        applyStimulus(ADDR_CTRL, 32'h5);
        repeat (3) @(negedge clk);
        checkOutput("d_ss_idle_wr", 32'(wrData.size() - base), 32'd0);
        checkCsr("d_ss_idle_status", ADDR_STATUS, 32'h30);
        base = wrData.size();
        applyStimulus(ADDR_CTRL, 32'h1);
        applyStimulus(ADDR_CTRL, 32'h5);
        checkOutput("d_ss_busy_cs", {31'd0, pioBus.chipselect}, 32'd0);
        checkCsr("d_ss_busy_status", ADDR_STATUS, 32'h00);
        repeat (5) @(negedge clk);
        checkOutput("d_ss_busy_wr", 32'(wrData.size() - base), 32'd1);

        // Reset during WAIT of the second step
        applyStimulus(ADDR_CTRL, 32'h1);
        repeat (7) @(negedge clk);
        checkCsr("e_wait_status", ADDR_STATUS, 32'h11);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("e_rst_cs", {31'd0, pioBus.chipselect}, 32'd0);
        checkOutput("e_rst_wn", {31'd0, pioBus.write_n}, 32'd1);
        checkOutput("e_rst_addr", {30'd0, pioBus.address}, 32'd0);
        checkOutput("e_rst_wdata", pioBus.writedata, 32'd0);
        checkOutput("e_rst_irq", {31'd0, irq}, 32'd0);
        checkCsr("e_rst_status", ADDR_STATUS, 32'd0);
        checkCsr("e_rst_interval", ADDR_INTERVAL, 32'd0);
        checkCsr("e_rst_pat0", 3'd4, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
